// File: rtl/kpt_stream_out_if.sv
// Word stream from kpt_stream_out to the CORE output port.
// A word moves on a rising edge where out_valid & out_ready are both high.
interface kpt_stream_out_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/kpt_stream_out.sv
// Serialises the two keypoint memories into a header/row/col/trailer word stream.
// The memory read is registered externally, so each keypoint costs a read and a wait cycle.
module kpt_stream_out #(
  parameter int          MAX_KPT = 2000,
  parameter int          AW      = 11,
  parameter logic [15:0] TRAILER = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [AW-1:0] kpt1_cnt_i,
  input  logic [AW-1:0] kpt2_cnt_i,
  output logic          kpt_rd_en_o,
  output logic          kpt_rd_sel_o,
  output logic [AW-1:0] kpt_rd_addr_o,
  input  logic [18:0]   kpt_rd_data_i,
  kpt_stream_out_if.master out_if,
  output logic          busy_o,
  output logic          done_o,
  output logic [3:0]    state_o
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_HDR   = 4'd1;
  localparam logic [3:0] S_RD    = 4'd2;
  localparam logic [3:0] S_WT    = 4'd3;
  localparam logic [3:0] S_ROW   = 4'd4;
  localparam logic [3:0] S_COL   = 4'd5;
  localparam logic [3:0] S_NXT   = 4'd6;
  localparam logic [3:0] S_TRAIL = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [AW-1:0] MAX_CNT = AW'(MAX_KPT);

  logic [3:0]    state_q, state_d;
  logic          layer_q, layer_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] cnt1_q, cnt1_d;
  logic [AW-1:0] cnt2_q, cnt2_d;
  logic [18:0]   hold_q, hold_d;

  logic [AW-1:0] cur_cnt;
  logic [AW-1:0] idx_inc;
  logic          xfer;

  function automatic logic [AW-1:0] clamp_cnt(input logic [AW-1:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  assign cur_cnt = layer_q ? cnt2_q : cnt1_q;
  assign idx_inc = idx_q + AW'(1);
  assign xfer    = out_if.out_valid & out_if.out_ready;

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    idx_d   = idx_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        // Counts are only latched here, so a start while streaming is ignored.
        if (start_i) begin
          cnt1_d  = clamp_cnt(kpt1_cnt_i);
          cnt2_d  = clamp_cnt(kpt2_cnt_i);
          layer_d = 1'b0;
          idx_d   = '0;
          state_d = S_HDR;
        end
      end
      S_HDR:   if (xfer) state_d = (cur_cnt == '0) ? S_NXT : S_RD;
      S_RD:    state_d = S_WT;
      S_WT: begin
        hold_d  = kpt_rd_data_i;
        state_d = S_ROW;
      end
      S_ROW:   if (xfer) state_d = S_COL;
      S_COL: begin
        if (xfer) begin
          idx_d   = idx_inc;
          state_d = (idx_inc == cur_cnt) ? S_NXT : S_RD;
        end
      end
      S_NXT: begin
        if (!layer_q) begin
          layer_d = 1'b1;
          idx_d   = '0;
          state_d = S_HDR;
        end else begin
          state_d = S_TRAIL;
        end
      end
      S_TRAIL: if (xfer) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      layer_q <= 1'b0;
      idx_q   <= '0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      idx_q   <= idx_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      hold_q  <= hold_d;
    end
  end

  // Output word is decoded from held state, so it stays stable during backpressure.
  always_comb begin
    out_if.out_valid = 1'b0;
    out_if.out_data  = 16'h0000;
    case (state_q)
      S_HDR: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = {3'b101, layer_q, 1'b0, 11'(cur_cnt)};
      end
      S_ROW: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = {7'b0, hold_q[18:10]};
      end
      S_COL: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = {6'b0, hold_q[9:0]};
      end
      S_TRAIL: begin
        out_if.out_valid = 1'b1;
        out_if.out_data  = TRAILER;
      end
      default: ;
    endcase
  end

  assign kpt_rd_en_o   = (state_q == S_RD);
  assign kpt_rd_sel_o  = layer_q;
  assign kpt_rd_addr_o = idx_q;
  assign busy_o        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o        = (state_q == S_DONE);
  assign state_o       = state_q;

endmodule
